// File: rtl/mcpu_mem_arb_pkg.sv
// Shared types and helpers for the MCPU memory-port arbiter.
// The id width is sized for the largest supported requester count so the
// in-flight entry type is the same for every NREQ configuration.
package mcpu_mem_arb_pkg;

    localparam int ARB_NREQ_MAX = 8;
    localparam int ARB_ID_W     = $clog2(ARB_NREQ_MAX);

    typedef struct packed {
        logic                vld;
        logic [ARB_ID_W-1:0] id;
    } inflight_t;

    // Byte-enable width for a given data width.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Next round-robin position after id, wrapping modulo n.
    function automatic logic [ARB_ID_W-1:0] ptr_next(input logic [ARB_ID_W-1:0] id,
                                                     input int n);
        return (int'(id) == n - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/mcpu_rr_pick.sv
// Rotating priority encoder: the first set request at or above ptr, wrapping
// modulo N, wins. Purely combinational so it can serve any core arbiter.
module mcpu_rr_pick
    import mcpu_mem_arb_pkg::*;
#(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] id,
    output logic            hit
);

    // Scan distances from the pointer; the nearest requesting slot wins.
    always_comb begin
        gnt = '0;
        id  = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!hit && req[i] && (((i - int'(ptr) + N) % N) == k)) begin
                    hit    = 1'b1;
                    gnt[i] = 1'b1;
                    id     = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mcpu_mem_arb.sv
// Round-robin arbiter sharing the core memory port between NREQ requesters.
// Read ids ride a MEM_LAT-deep pipeline so each response returns to its issuer.
// Optional macro MCPU_MEM_ARB_LOCK_EN adds req_lock for atomic read-modify-write.
module mcpu_mem_arb
    import mcpu_mem_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                       clkrst_core_clk,
    input  logic                       clkrst_core_rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*(DATA_W/8)-1:0] req_we,
`ifdef MCPU_MEM_ARB_LOCK_EN
    input  logic [NREQ-1:0]            req_lock,
`endif
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       mem_cmd_valid,
    input  logic                       mem_cmd_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_we,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int BE_W = be_width(DATA_W);

    logic [ARB_ID_W-1:0]       ptr_q;
    logic [NREQ-1:0]           elig;
    logic [NREQ-1:0]           gnt;
    logic [ARB_ID_W-1:0]       win_id;
    logic                      win_hit;
    logic                      win_lock;
    logic                      accept;
    logic                      rd_accept;
    inflight_t [MEM_LAT:1]     trk_p;

`ifdef MCPU_MEM_ARB_LOCK_EN
    logic                      lock_q;
    logic [ARB_ID_W-1:0]       lock_id_q;

    // While a lock is held only the owning requester may compete.
    always_comb begin
        elig = req_valid;
        if (lock_q) begin
            for (int i = 0; i < NREQ; i++) begin
                elig[i] = req_valid[i] && (lock_id_q == ARB_ID_W'(i));
            end
        end
    end

    assign win_lock = |(req_lock & gnt);

    // Lock is taken by an accept with req_lock set and dropped by one without.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (accept) begin
            lock_q    <= win_lock;
            lock_id_q <= win_id;
        end
    end
`else
    assign elig     = req_valid;
    assign win_lock = 1'b0;
`endif

    mcpu_rr_pick #(
        .N    (NREQ),
        .ID_W (ARB_ID_W)
    ) u_pick (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .id  (win_id),
        .hit (win_hit)
    );

    // Nothing is offered to memory or acknowledged while reset is asserted.
    assign mem_cmd_valid = win_hit && clkrst_core_rst_n;
    assign req_ready     = (mem_cmd_valid && mem_cmd_ready) ? gnt : '0;
    assign accept        = mem_cmd_valid && mem_cmd_ready;
    assign rd_accept     = accept && (mem_we == '0);

    // Route the winning requester's command onto the memory port.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = req_wdata[i*DATA_W +: DATA_W];
                mem_we    = req_we[i*BE_W +: BE_W];
            end
        end
    end

    // Priority pointer moves past the winner on every unlocked accept.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            ptr_q <= '0;
        end else if (accept && !win_lock) begin
            ptr_q <= ptr_next(win_id, NREQ);
        end
    end

    // Stage 1..MEM_LAT: in-flight read ids, shifting every cycle.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            trk_p <= '0;
        end else begin
            trk_p[1].vld <= rd_accept;
            trk_p[1].id  <= win_id;
            for (int s = 2; s <= MEM_LAT; s++) begin
                trk_p[s] <= trk_p[s-1];
            end
        end
    end

    // Response stage: register memory data and steer the strobe to the issuer.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_valid[i] <= trk_p[MEM_LAT].vld && (trk_p[MEM_LAT].id == ARB_ID_W'(i));
            end
            if (trk_p[MEM_LAT].vld) begin
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mcpu_mem_arb.sv
// Bench for mcpu_mem_arb: a table of arbitration vectors, hand-written
// sequences for latency/reset/write corner cases, and a response scoreboard
// fed by an independent round-robin model and a behavioural memory.
module tb_mcpu_mem_arb;

    localparam int NREQ    = 3;
    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;
    localparam int BE_W    = DATA_W / 8;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ*BE_W-1:0]   req_we;
`ifdef MCPU_MEM_ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [BE_W-1:0]        mem_we;
    logic [DATA_W-1:0]      mem_rdata;

    mcpu_mem_arb #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_we            (req_we),
`ifdef MCPU_MEM_ARB_LOCK_EN
        .req_lock          (req_lock),
`endif
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .mem_cmd_valid     (mem_cmd_valid),
        .mem_cmd_ready     (mem_cmd_ready),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_we            (mem_we),
        .mem_rdata         (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
        mem[8'h10] = 32'hDEAD_BEEF;
        for (int k = 0; k < MEM_LAT; k++) rd_pipe[k] = '0;
    end

    always @(posedge clk) begin
        if (mem_cmd_valid && mem_cmd_ready) begin
            for (int b = 0; b < BE_W; b++)
                if (mem_we[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            rd_pipe[0] <= mem[mem_addr[7:0]];
        end else begin
            rd_pipe[0] <= '0;
        end
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [NREQ-1:0]   oh;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ptr_m = 0;
`ifdef MCPU_MEM_ARB_LOCK_EN
    logic lock_m = 1'b0;
    int   lock_id_m = 0;
`endif

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] elig;
        logic [NREQ-1:0] exp_rdy;
        int              win;
        exp_t            e;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            ptr_m = 0;
`ifdef MCPU_MEM_ARB_LOCK_EN
            lock_m = 1'b0;
`endif
            chk("sb_rst_rsp_valid", rsp_valid, '0);
            chk("sb_rst_req_ready", req_ready, '0);
            chk("sb_rst_cmd_valid", mem_cmd_valid, 1'b0);
        end else begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("sb_rsp_valid", rsp_valid, e.oh);
                chk("sb_rsp_rdata", rsp_rdata, e.data);
            end else begin
                chk("sb_rsp_idle", rsp_valid, '0);
            end

            elig = req_valid;
`ifdef MCPU_MEM_ARB_LOCK_EN
            if (lock_m) elig = req_valid & (NREQ'(1) << lock_id_m);
`endif
            win = pick(elig, ptr_m);
            exp_rdy = (win >= 0 && mem_cmd_ready) ? (NREQ'(1) << win) : '0;
            chk("sb_req_ready", req_ready, exp_rdy);
            chk("sb_cmd_valid", mem_cmd_valid, (win >= 0));
            if (win >= 0) begin
                chk("sb_mem_addr", mem_addr, req_addr[win*ADDR_W +: ADDR_W]);
                chk("sb_mem_we", mem_we, req_we[win*BE_W +: BE_W]);
                if (mem_cmd_ready) begin
                    if (req_we[win*BE_W +: BE_W] == '0) begin
                        e.oh   = NREQ'(1) << win;
                        e.data = mem[req_addr[win*ADDR_W +: 8]];
                        e.due  = cyc + MEM_LAT + 1;
                        sb.push_back(e);
                    end
`ifdef MCPU_MEM_ARB_LOCK_EN
                    if (req_lock[win]) begin
                        lock_m = 1'b1;
                        lock_id_m = win;
                    end else begin
                        lock_m = 1'b0;
                        ptr_m = (win + 1) % NREQ;
                    end
`else
                    ptr_m = (win + 1) % NREQ;
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [NREQ-1:0] vld;
        logic            rdy;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_cv;
        int              exp_win;
    } vec_t;

    vec_t tbl [20];

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [BE_W-1:0] we);
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
        req_we[i*BE_W +: BE_W]        = we;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b1, 0};
        tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 1};
        tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2};
        tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 0};
        tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 1};
        tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2};
        tbl[6]  = '{3'b110, 1'b0, 3'b000, 1'b1, 1};
        tbl[7]  = '{3'b110, 1'b0, 3'b000, 1'b1, 1};
        tbl[8]  = '{3'b110, 1'b0, 3'b000, 1'b1, 1};
        tbl[9]  = '{3'b110, 1'b0, 3'b000, 1'b1, 1};
        tbl[10] = '{3'b110, 1'b1, 3'b010, 1'b1, 1};
        tbl[11] = '{3'b100, 1'b1, 3'b100, 1'b1, 2};
        tbl[12] = '{3'b000, 1'b1, 3'b000, 1'b0, -1};
        tbl[13] = '{3'b101, 1'b1, 3'b001, 1'b1, 0};
        tbl[14] = '{3'b101, 1'b1, 3'b100, 1'b1, 2};
        tbl[15] = '{3'b011, 1'b1, 3'b001, 1'b1, 0};
        tbl[16] = '{3'b011, 1'b1, 3'b010, 1'b1, 1};
        tbl[17] = '{3'b011, 1'b1, 3'b001, 1'b1, 0};
        tbl[18] = '{3'b000, 1'b0, 3'b000, 1'b0, -1};
        tbl[19] = '{3'b010, 1'b1, 3'b010, 1'b1, 1};

        rst_n = 1'b0;
        mem_cmd_ready = 1'b1;
        req_valid = '1;
        req_addr = '0;
        req_wdata = '0;
        req_we = '0;
`ifdef MCPU_MEM_ARB_LOCK_EN
        req_lock = '0;
`endif
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(32'h20 + i), '0, '0);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_cmd_valid", mem_cmd_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        next_cyc();
        rst_n = 1'b1;

        // arbitration vectors, applied back to back from pointer 0
        for (int r = 0; r < 20; r++) begin
            req_valid = tbl[r].vld;
            mem_cmd_ready = tbl[r].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_req_ready", r), req_ready, tbl[r].exp_rdy);
            chk($sformatf("vec%0d_cmd_valid", r), mem_cmd_valid, tbl[r].exp_cv);
            if (tbl[r].exp_win >= 0)
                chk($sformatf("vec%0d_mem_addr", r), mem_addr, ADDR_W'(32'h20 + tbl[r].exp_win));
            next_cyc();
        end
        req_valid = '0;
        mem_cmd_ready = 1'b1;
        repeat (MEM_LAT + 2) next_cyc();

        // single read: req0 reads 0x10, response exactly MEM_LAT+1 cycles later
        set_req(0, 30'h10, '0, '0);
        req_valid = 3'b001;
        @(negedge clk);
        chk("rd_req_ready", req_ready, 3'b001);
        next_cyc();
        req_valid = '0;
        @(negedge clk);
        chk("rd_lat1_rsp_valid", rsp_valid, '0);
        @(negedge clk);
        chk("rd_lat2_rsp_valid", rsp_valid, '0);
        @(negedge clk);
        chk("rd_lat3_rsp_valid", rsp_valid, 3'b001);
        chk("rd_lat3_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rd_hold_rsp_valid", rsp_valid, '0);
        chk("rd_hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        next_cyc();

        // write from req0 then read of the same word from req2
        set_req(0, 30'h30, 32'h5, 4'hF);
        req_valid = 3'b001;
        @(negedge clk);
        chk("wr_req_ready", req_ready, 3'b001);
        next_cyc();
        set_req(0, 30'h30, '0, '0);
        set_req(2, 30'h30, '0, '0);
        req_valid = 3'b100;
        @(negedge clk);
        chk("wr_rd_req_ready", req_ready, 3'b100);
        next_cyc();
        req_valid = '0;
        @(negedge clk);
        chk("wr_gap_rsp_valid", rsp_valid, '0);
        @(negedge clk);
        chk("wr_norsp_rsp_valid", rsp_valid, '0);
        @(negedge clk);
        chk("wr_rd_rsp_valid", rsp_valid, 3'b100);
        chk("wr_rd_rsp_rdata", rsp_rdata, 32'h5);
        next_cyc();

        // reset while a read from req1 is in flight
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(32'h20 + i), '0, '0);
        req_valid = 3'b010;
        @(negedge clk);
        chk("rstrd_req_ready", req_ready, 3'b010);
        next_cyc();
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("rstrd_in_rst_rsp_valid", rsp_valid, '0);
        next_cyc();
        rst_n = 1'b1;
        for (int k = 0; k < MEM_LAT + 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstrd_drop%0d_rsp_valid", k), rsp_valid, '0);
        end
        next_cyc();
        req_valid = 3'b111;
        @(negedge clk);
        chk("rstrd_ptr0_req_ready", req_ready, 3'b001);
        next_cyc();
        req_valid = '0;
        repeat (MEM_LAT + 2) next_cyc();

`ifdef MCPU_MEM_ARB_LOCK_EN
        // pointer is 1 here; req1 locks, then its write beats waiting req0
        req_valid = 3'b011;
        req_lock = 3'b010;
        @(negedge clk);
        chk("lock_first_req_ready", req_ready, 3'b010);
        next_cyc();
        req_valid = 3'b001;
        @(negedge clk);
        chk("lock_idle_req_ready", req_ready, 3'b000);
        chk("lock_idle_cmd_valid", mem_cmd_valid, 1'b0);
        next_cyc();
        req_valid = 3'b011;
        req_lock = '0;
        set_req(1, 30'h40, 32'h1234_5678, 4'hF);
        @(negedge clk);
        chk("lock_wr_req_ready", req_ready, 3'b010);
        next_cyc();
        req_valid = 3'b001;
        @(negedge clk);
        chk("lock_rel_req_ready", req_ready, 3'b001);
        next_cyc();
        req_valid = '0;
        set_req(1, 30'h21, '0, '0);
`endif

        repeat (MEM_LAT + 3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
